// File: rtl/sum_acc_pkg.sv
// rtl/sum_acc_pkg.sv - shared state enum, default widths and frame-counter width helper
package sum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int IN_W_DEF  = 4;
  localparam int ACC_W_DEF = 8;

  // frame_cnt must reach BURST_LEN itself, hence the +1
  function automatic int cnt_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/acc_sat_adder.sv
// rtl/acc_sat_adder.sv - ACC_W + (IN_W+1) adder with carry out; clamps to all-ones when ACC_SAT_EN is defined
module acc_sat_adder #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [IN_W:0]    i_val,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_carry
);

  logic [ACC_W:0] w_full;

  assign w_full  = {1'b0, i_acc} + {{(ACC_W - IN_W){1'b0}}, i_val};
  assign o_carry = w_full[ACC_W];

`ifdef ACC_SAT_EN
  // once clamped, any further non-zero add carries again, so the clamp persists
  assign o_sum = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - accumulates BURST_LEN adder results into a frame total on a valid/ready output; ACC_SAT_EN selects clamping
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int IN_W      = IN_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int BURST_LEN = 16,
  parameter int DROP_W    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [IN_W-1:0]                 in_sum,
  input  logic                            in_c5,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ACC_W-1:0]                out_acc,
  output logic                            out_ovf,
  output logic [cnt_w(BURST_LEN)-1:0]     frame_cnt,
  output logic [DROP_W-1:0]               out_drop
);

  localparam int              CNT_W = cnt_w(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;
  logic [DROP_W-1:0]  r_drop;
  logic               r_valid;

  state_t             w_state_next;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_ovf_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [DROP_W-1:0]  w_drop_next;
  logic               w_start;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [ACC_W-1:0]   w_add_a;
  logic [ACC_W-1:0]   w_sum;
  logic               w_carry;

  // a fresh frame adds onto zero, so its first sample can never carry
  assign w_add_a   = (r_state == ACCUM) ? r_acc : '0;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  acc_sat_adder #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_adder (
    .i_acc   (w_add_a),
    .i_val   ({in_c5, in_sum}),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_drop  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_ovf   <= w_ovf_next;
      r_cnt   <= w_cnt_next;
      r_drop  <= w_drop_next;
      r_valid <= (w_state_next == HOLD);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_ovf_next   = r_ovf;
    w_cnt_next   = r_cnt;
    w_drop_next  = r_drop;
    w_start      = 1'b0;
    case (r_state)
      IDLE: w_start = in_valid;
      ACCUM: begin
        if (in_valid) begin
          w_acc_next = w_sum;
          w_ovf_next = r_ovf | w_carry;
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == LAST) w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (in_valid) begin
            w_start = 1'b1;
          end else begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end
        end else if (in_valid && (r_drop != {DROP_W{1'b1}})) begin
          w_drop_next = r_drop + DROP_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_start) begin
      w_acc_next   = w_sum;
      w_ovf_next   = 1'b0;
      w_cnt_next   = CNT_W'(1);
      w_state_next = (BURST_LEN == 1) ? HOLD : ACCUM;
    end
  end

  assign out_valid = r_valid;
  assign out_acc   = r_acc;
  assign out_ovf   = r_ovf;
  assign frame_cnt = r_cnt;
  assign out_drop  = r_drop;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - self-checking bench for sum_accumulator (table vectors, corner sequences, random vs. model; honours ACC_SAT_EN)
module tb_sum_accumulator;

  localparam int BL = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_sum = '0;
  logic       in_c5 = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_acc;
  logic       out_ovf;
  logic [4:0] frame_cnt;
  logic [7:0] out_drop;

  always #5 clk = ~clk;

  sum_accumulator #(.IN_W(4), .ACC_W(8), .BURST_LEN(BL), .DROP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_c5     (in_c5),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .frame_cnt (frame_cnt),
    .out_drop  (out_drop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: unbounded running total of the current frame
  int m_total = 0;
  int m_cnt   = 0;
  bit m_hold  = 0;
  int m_drop  = 0;

`ifdef ACC_SAT_EN
  localparam int ACC31 = 255;
`else
  localparam int ACC31 = 240;
`endif

  function automatic int exp_acc(input int t);
`ifdef ACC_SAT_EN
    return (t > 255) ? 255 : t;
`else
    return t % 256;
`endif
  endfunction

  function automatic void model_step(input bit r, input bit val, input int v, input bit rdy);
    if (r) begin
      m_total = 0; m_cnt = 0; m_hold = 0; m_drop = 0;
    end else if (m_hold) begin
      if (rdy && val) begin
        m_total = v; m_cnt = 1; m_hold = (BL == 1);
      end else if (rdy) begin
        m_hold = 0; m_cnt = 0;
      end else if (val) begin
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
    end else if (val) begin
      m_total = (m_cnt == 0) ? v : m_total + v;
      m_cnt   = m_cnt + 1;
      if (m_cnt == BL) m_hold = 1;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit val, input logic [4:0] v, input bit rdy);
    @(negedge clk);
    rst = r; in_valid = val; in_sum = v[3:0]; in_c5 = v[4]; out_ready = rdy;
    @(posedge clk);
    model_step(r, val, int'(v), rdy);
    #1;
    chk("valid", 32'(out_valid), 32'(m_hold));
    chk("frame_cnt", 32'(frame_cnt), m_cnt);
    chk("drop", 32'(out_drop), m_drop);
    if (m_cnt != 0) begin
      chk("acc", 32'(out_acc), exp_acc(m_total));
      chk("ovf", 32'(out_ovf), 32'(m_total > 255));
    end
  endtask

  typedef struct {
    bit rst; bit val; int v; bit rdy;
    bit chk; int e_valid; int e_acc; int e_ovf; int e_cnt; int e_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input bit val, input int v, input bit rdy);
    vec_t e;
    e = '{r, val, v, rdy, 1'b0, 0, 0, 0, 0, 0};
    vecs.push_back(e);
  endfunction

  // -1 in an expected field means don't care
  function automatic void add_chk(input bit r, input bit val, input int v, input bit rdy,
                                  input int ev, input int ea, input int eo, input int ec, input int ed);
    vec_t e;
    e = '{r, val, v, rdy, 1'b1, ev, ea, eo, ec, ed};
    vecs.push_back(e);
  endfunction

  initial begin
    // reset with in_valid asserted
    add_chk(1, 1, 5, 0, 0, 0, 0, 0, 0);
    add_chk(1, 1, 5, 0, 0, 0, 0, 0, 0);
    // 16 x 5, then held with out_ready low
    for (int i = 0; i < 14; i++) add(0, 1, 5, 0);
    add_chk(0, 1, 5, 0, 0, 75, 0, 15, 0);
    add_chk(0, 1, 5, 0, 1, 80, 0, 16, 0);
    for (int i = 0; i < 3; i++) add_chk(0, 0, 0, 0, 1, 80, 0, 16, 0);
    // drops in HOLD, then handshake with same-cycle sample
    add_chk(0, 1, 3, 0, 1, 80, 0, 16, 1);
    add_chk(0, 1, 3, 0, 1, 80, 0, 16, 2);
    add_chk(0, 1, 7, 1, 0, 7, 0, 1, 2);
    for (int i = 0; i < 14; i++) add(0, 1, 7, 0);
    add_chk(0, 1, 7, 0, 1, 112, 0, 16, 2);
    add_chk(0, 0, 0, 1, 0, -1, -1, 0, 2);
    // 16 x 31 overflows
    for (int i = 0; i < 15; i++) add(0, 1, 31, 0);
    add_chk(0, 1, 31, 0, 1, ACC31, 1, 16, 2);
    add_chk(0, 0, 0, 1, 0, -1, -1, 0, 2);
    // reset mid-frame leaves no residue
    for (int i = 0; i < 4; i++) add(0, 1, 9, 0);
    add_chk(0, 1, 9, 0, 0, 45, 0, 5, 2);
    add_chk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) add(0, 1, 2, 0);
    add_chk(0, 1, 2, 0, 1, 32, 0, 16, 0);
    add_chk(0, 0, 0, 1, 0, -1, -1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].val, 5'(vecs[i].v), vecs[i].rdy);
      if (vecs[i].chk) begin
        chk("tbl_valid", 32'(out_valid), vecs[i].e_valid);
        if (vecs[i].e_acc >= 0) chk("tbl_acc", 32'(out_acc), vecs[i].e_acc);
        if (vecs[i].e_ovf >= 0) chk("tbl_ovf", 32'(out_ovf), vecs[i].e_ovf);
        chk("tbl_cnt", 32'(frame_cnt), vecs[i].e_cnt);
        chk("tbl_drop", 32'(out_drop), vecs[i].e_drop);
      end
    end

    // gaps between valid results
    for (int k = 0; k < BL; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) cycle(0, 0, 5'd0, 1'b0);
      cycle(0, 1, 5'd1, 1'b0);
    end
    chk("gap_acc", 32'(out_acc), 32'h10);
    chk("gap_valid", 32'(out_valid), 1);

    // drop counter saturates
    for (int i = 0; i < 260; i++) cycle(0, 1, 5'd4, 1'b0);
    chk("drop_sat", 32'(out_drop), 255);
    chk("drop_sat_acc", 32'(out_acc), 32'h10);
    cycle(0, 0, 5'd0, 1'b1);
    chk("idle_valid", 32'(out_valid), 0);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
